// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants one result producer per cycle (fixed priority
// with aging, or round-robin) and broadcasts its word, optionally registered.
module cdb_arbiter #(
  parameter int N_UNITS  = 3,
  parameter int CDB_W    = 40,
  parameter int RR       = 0,
  parameter int MAX_WAIT = 8,
  parameter int OUT_REG  = 1
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          flush,
  input  logic [N_UNITS-1:0][CDB_W-1:0] i_cdb,
  input  logic [N_UNITS-1:0]            i_valid,
  output logic [N_UNITS-1:0]            o_ready,
  output logic [CDB_W-1:0]              o_cdb,
  output logic                          o_cdb_valid,
  output logic [$clog2(N_UNITS)-1:0]    o_grant_id
);
  localparam int ID_W = $clog2(N_UNITS);

  logic [ID_W-1:0]    ptr;
  logic [N_UNITS-1:0] aged;
  logic [ID_W-1:0]    pick;
  logic               grant_en;
  logic [CDB_W-1:0]   sel_cdb;
  logic [ID_W-1:0]    sel_id;

  // Modular add that wraps at N_UNITS, so non-power-of-two counts never reach unused indices.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= N_UNITS) sum = sum - N_UNITS;
    return ID_W'(sum);
  endfunction

  always_comb begin
    pick = '0;
    if (RR != 0) begin
      for (int i = N_UNITS - 1; i >= 0; i--)
        if (i_valid[wrap_add(ptr, i)]) pick = wrap_add(ptr, i);
    end else begin
      for (int i = N_UNITS - 1; i >= 0; i--)
        if (i_valid[i]) pick = ID_W'(i);
      // Aged requesters override plain priority; the later loop wins.
      for (int i = N_UNITS - 1; i >= 0; i--)
        if (i_valid[i] && aged[i]) pick = ID_W'(i);
    end
  end

  assign grant_en = nrst & ~flush & (|i_valid);
  assign o_ready  = grant_en ? (N_UNITS'(1) << pick) : '0;
  assign sel_cdb  = grant_en ? i_cdb[pick] : '0;
  assign sel_id   = grant_en ? pick : '0;

  generate
    if (RR == 0 && MAX_WAIT > 0) begin : g_aging
      localparam int WAIT_W = $clog2(MAX_WAIT + 1);
      logic [WAIT_W-1:0] wait_cnt [N_UNITS];

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          for (int k = 0; k < N_UNITS; k++) wait_cnt[k] <= '0;
        end else if (!flush) begin
          for (int k = 0; k < N_UNITS; k++) begin
            if (!i_valid[k] || o_ready[k])
              wait_cnt[k] <= '0;
            else if (wait_cnt[k] != WAIT_W'(MAX_WAIT))
              wait_cnt[k] <= wait_cnt[k] + WAIT_W'(1);
          end
        end
      end

      always_comb begin
        aged = '0;
        for (int k = 0; k < N_UNITS; k++)
          aged[k] = (wait_cnt[k] == WAIT_W'(MAX_WAIT));
      end
    end else begin : g_no_aging
      assign aged = '0;
    end

    if (RR != 0) begin : g_rr_ptr
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
          ptr <= '0;
        else if (grant_en)
          ptr <= wrap_add(pick, 1);
      end
    end else begin : g_no_ptr
      assign ptr = '0;
    end

    if (OUT_REG != 0) begin : g_out_reg
      // A flush clears grant_en, so the register loads an invalid, zeroed word.
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          o_cdb       <= '0;
          o_cdb_valid <= 1'b0;
          o_grant_id  <= '0;
        end else begin
          o_cdb       <= sel_cdb;
          o_cdb_valid <= grant_en;
          o_grant_id  <= sel_id;
        end
      end
    end else begin : g_out_comb
      assign o_cdb       = sel_cdb;
      assign o_cdb_valid = grant_en;
      assign o_grant_id  = sel_id;
    end
  endgenerate

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: four instances cover aging, plain priority,
// round-robin and combinational broadcast; a negedge monitor checks every broadcast.
module tb_cdb_arbiter;
  typedef struct {
    int          id;
    logic [39:0] word;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst;
  logic flush;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  logic [2:0][39:0] words3;
  logic [4:0][39:0] words5;

  logic [2:0]  fp_valid, fp_ready;
  logic [39:0] fp_cdb;
  logic        fp_cv;
  logic [1:0]  fp_gid;

  logic [2:0]  fz_valid, fz_ready;
  logic [39:0] fz_cdb;
  logic        fz_cv;
  logic [1:0]  fz_gid;

  logic [2:0]  rr_valid, rr_ready;
  logic [39:0] rr_cdb;
  logic        rr_cv;
  logic [1:0]  rr_gid;

  logic [4:0]  cb_valid, cb_ready;
  logic [39:0] cb_cdb;
  logic        cb_cv;
  logic [2:0]  cb_gid;

  cdb_arbiter #(.N_UNITS(3), .CDB_W(40), .RR(0), .MAX_WAIT(3), .OUT_REG(1)) dut_fp (
    .clk(clk), .nrst(nrst), .flush(flush), .i_cdb(words3), .i_valid(fp_valid),
    .o_ready(fp_ready), .o_cdb(fp_cdb), .o_cdb_valid(fp_cv), .o_grant_id(fp_gid));

  cdb_arbiter #(.N_UNITS(3), .CDB_W(40), .RR(0), .MAX_WAIT(0), .OUT_REG(1)) dut_fz (
    .clk(clk), .nrst(nrst), .flush(flush), .i_cdb(words3), .i_valid(fz_valid),
    .o_ready(fz_ready), .o_cdb(fz_cdb), .o_cdb_valid(fz_cv), .o_grant_id(fz_gid));

  cdb_arbiter #(.N_UNITS(3), .CDB_W(40), .RR(1), .MAX_WAIT(8), .OUT_REG(1)) dut_rr (
    .clk(clk), .nrst(nrst), .flush(flush), .i_cdb(words3), .i_valid(rr_valid),
    .o_ready(rr_ready), .o_cdb(rr_cdb), .o_cdb_valid(rr_cv), .o_grant_id(rr_gid));

  cdb_arbiter #(.N_UNITS(5), .CDB_W(40), .RR(0), .MAX_WAIT(8), .OUT_REG(0)) dut_cb (
    .clk(clk), .nrst(nrst), .flush(flush), .i_cdb(words5), .i_valid(cb_valid),
    .o_ready(cb_ready), .o_cdb(cb_cdb), .o_cdb_valid(cb_cv), .o_grant_id(cb_gid));

  always @(posedge clk) cyc <= cyc + 1;

  // Unit k always presents {0x56+k, 3+k}; unit 4 therefore presents 0x5A_00000007.
  function automatic logic [39:0] unit_word(input int k);
    unit_word = {8'h56 + 8'(k), 32'h3 + 32'(k)};
  endfunction

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Instance 3 broadcasts in the grant cycle; the others one cycle later.
  task automatic push_exp(input int d, input int id);
    exp_t e;
    e.id   = id;
    e.word = unit_word(id);
    e.due  = (d == 3) ? cyc : cyc + 1;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic applyStimulus(input int d, input logic [4:0] valid, input logic fl,
                               input logic [4:0] exp_ready, input string name);
    logic [4:0] act;
    @(posedge clk);
    #1;
    flush = fl;
    case (d)
      0: fp_valid = valid[2:0];
      1: fz_valid = valid[2:0];
      2: rr_valid = valid[2:0];
      default: cb_valid = valid;
    endcase
    for (int k = 0; k < 5; k++)
      if (exp_ready[k]) push_exp(d, k);
    @(negedge clk);
    case (d)
      0: act = {2'b00, fp_ready};
      1: act = {2'b00, fz_ready};
      2: act = {2'b00, rr_ready};
      default: act = cb_ready;
    endcase
    check_eq(name, 64'(act), 64'(exp_ready));
  endtask

  task automatic checkOutput(input int d, input logic v, input logic [39:0] cdb, input int gid);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (d)
      0: if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1'b1; end
      2: if (q2.size() > 0 && q2[0].due == cyc) begin e = q2.pop_front(); have = 1'b1; end
      default: if (q3.size() > 0 && q3[0].due == cyc) begin e = q3.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (have) begin
      if (v !== 1'b1 || cdb !== e.word || gid != e.id) begin
        errors++;
        $display("[TB] FAIL bcast%0d cyc%0d: got valid=%b id=%0d word=%h, expected valid=1 id=%0d word=%h",
                 d, cyc, v, gid, cdb, e.id, e.word);
      end
    end else if (v !== 1'b0 || cdb !== 40'h0 || gid != 0) begin
      errors++;
      $display("[TB] FAIL idle%0d cyc%0d: got valid=%b id=%0d word=%h, expected valid=0 id=0 word=0",
               d, cyc, v, gid, cdb);
    end
  endtask

  always @(negedge clk) begin
    checkOutput(0, fp_cv, fp_cdb, int'(fp_gid));
    checkOutput(1, fz_cv, fz_cdb, int'(fz_gid));
    checkOutput(2, rr_cv, rr_cdb, int'(rr_gid));
    checkOutput(3, cb_cv, cb_cdb, int'(cb_gid));
  end

  initial begin
    for (int k = 0; k < 3; k++) words3[k] = unit_word(k);
    for (int k = 0; k < 5; k++) words5[k] = unit_word(k);
    nrst = 1'b0;
    flush = 1'b0;
    fp_valid = '0;
    fz_valid = '0;
    rr_valid = '0;
    cb_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_cv", 64'(fp_cv), 64'd0);
    check_eq("rst_gid", 64'(fp_gid), 64'd0);
    nrst = 1'b1;

    // Reset asserted mid-cycle while every unit requests.
    applyStimulus(0, 5'b00111, 1'b0, 5'b00001, "fp_pre_rst_a");
    applyStimulus(0, 5'b00111, 1'b0, 5'b00001, "fp_pre_rst_b");
    #2;
    nrst = 1'b0;
    #1;
    check_eq("rst_mid_cv", 64'(fp_cv), 64'd0);
    check_eq("rst_mid_ready", 64'(fp_ready), 64'd0);
    check_eq("rst_mid_cdb", 64'(fp_cdb), 64'd0);
    check_eq("rst_mid_gid", 64'(fp_gid), 64'd0);
    q0.delete();
    @(posedge clk);
    #1;
    check_eq("rst_hold_ready", 64'(fp_ready), 64'd0);
    check_eq("rst_hold_cv", 64'(fp_cv), 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    check_eq("rst_release_ready", 64'(fp_ready), 64'b001);
    push_exp(0, 0);
    applyStimulus(0, 5'b00000, 1'b0, 5'b00000, "fp_idle0");

    // Aging with MAX_WAIT=3: unit 2 wins every fourth cycle over unit 0.
    applyStimulus(0, 5'b00101, 1'b0, 5'b00001, "age_c0");
    applyStimulus(0, 5'b00101, 1'b0, 5'b00001, "age_c1");
    applyStimulus(0, 5'b00101, 1'b0, 5'b00001, "age_c2");
    applyStimulus(0, 5'b00101, 1'b0, 5'b00100, "age_c3");
    applyStimulus(0, 5'b00101, 1'b0, 5'b00001, "age_c4");
    applyStimulus(0, 5'b00101, 1'b0, 5'b00001, "age_c5");
    applyStimulus(0, 5'b00101, 1'b0, 5'b00001, "age_c6");
    applyStimulus(0, 5'b00101, 1'b0, 5'b00100, "age_c7");
    applyStimulus(0, 5'b00000, 1'b0, 5'b00000, "fp_idle1");

    // Counters hold through flush: unit 2 needs one more unflushed cycle.
    applyStimulus(0, 5'b00101, 1'b0, 5'b00001, "hold_a");
    applyStimulus(0, 5'b00101, 1'b0, 5'b00001, "hold_b");
    applyStimulus(0, 5'b00101, 1'b1, 5'b00000, "hold_flush_a");
    applyStimulus(0, 5'b00101, 1'b1, 5'b00000, "hold_flush_b");
    applyStimulus(0, 5'b00101, 1'b0, 5'b00001, "hold_c");
    applyStimulus(0, 5'b00101, 1'b0, 5'b00100, "hold_d");
    applyStimulus(0, 5'b00000, 1'b0, 5'b00000, "fp_idle2");

    // Flush against a pending grant, then flush right after a grant.
    applyStimulus(0, 5'b00010, 1'b1, 5'b00000, "flush_kill");
    applyStimulus(0, 5'b00010, 1'b0, 5'b00010, "flush_regrant");
    applyStimulus(0, 5'b00010, 1'b1, 5'b00000, "flush_after");
    applyStimulus(0, 5'b00000, 1'b0, 5'b00000, "fp_idle3");

    // Plain fixed priority without aging: unit 2 starves.
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 5'b00110, 1'b0, 5'b00010, "fz_u1");
    applyStimulus(1, 5'b00011, 1'b0, 5'b00001, "fz_u0");
    applyStimulus(1, 5'b00100, 1'b0, 5'b00100, "fz_u2");
    applyStimulus(1, 5'b00000, 1'b0, 5'b00000, "fz_idle");

    // Round-robin rotation and wrap at N_UNITS-1.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(2, 5'b00111, 1'b0, 5'b00001, "rr_g0");
      applyStimulus(2, 5'b00111, 1'b0, 5'b00010, "rr_g1");
      applyStimulus(2, 5'b00111, 1'b0, 5'b00100, "rr_g2");
    end
    applyStimulus(2, 5'b00111, 1'b0, 5'b00001, "rr_p_to_1");
    applyStimulus(2, 5'b00001, 1'b0, 5'b00001, "rr_only0");
    applyStimulus(2, 5'b00111, 1'b0, 5'b00010, "rr_after_only0");
    applyStimulus(2, 5'b00000, 1'b0, 5'b00000, "rr_idle_hold");
    applyStimulus(2, 5'b00111, 1'b0, 5'b00100, "rr_hold_g2");
    applyStimulus(2, 5'b00111, 1'b1, 5'b00000, "rr_flush");
    applyStimulus(2, 5'b00111, 1'b0, 5'b00001, "rr_post_flush");
    applyStimulus(2, 5'b00110, 1'b0, 5'b00010, "rr_skip0");
    applyStimulus(2, 5'b00000, 1'b0, 5'b00000, "rr_idle");

    // Combinational broadcast, five units.
    applyStimulus(3, 5'b10000, 1'b0, 5'b10000, "cb_u4");
    applyStimulus(3, 5'b10010, 1'b0, 5'b00010, "cb_u1");
    applyStimulus(3, 5'b10000, 1'b1, 5'b00000, "cb_flush");
    applyStimulus(3, 5'b11111, 1'b0, 5'b00001, "cb_all");
    applyStimulus(3, 5'b00100, 1'b0, 5'b00100, "cb_u2");
    applyStimulus(3, 5'b00000, 1'b0, 5'b00000, "cb_idle");

    @(posedge clk);
    @(negedge clk);
    checks++;
    if (q0.size() + q1.size() + q2.size() + q3.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending broadcasts, expected 0",
               q0.size() + q1.size() + q2.size() + q3.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Parametrised common-data-bus arbiter for the out-of-order core. It replaces the fixed three-way priority mux in the core top level and generalises it in three ways: any number of result producers (ALU, MFU, MMU, future FPU/BRU result ports), selectable fixed-priority or round-robin grant, and an optional registered broadcast stage. Fixed-priority mode adds per-requester aging so low-priority units cannot starve. It also accepts the branch-mispredict flush. Exactly one result is broadcast to the reservation stations, the reorder buffer and the operand bypass per cycle.

## Interface
- N_UNITS, 3: number of requesting units, ≥2; index 0 is highest fixed priority.
- CDB_W, CDB_W (package): width of one CDB word, {rsv_id, data}.
- RR, 0: 0 = fixed priority with aging; 1 = round-robin.
- MAX_WAIT, 8: aging threshold in cycles (fixed-priority mode only); 0 disables aging.
- OUT_REG, 1: 0 = combinational broadcast in the same cycle; 1 = registered broadcast.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- flush  in  1  branch-mispredict flush (pred_miss).
- i_cdb  in  [N_UNITS][CDB_W]  per-unit result word.
- i_valid  in  N_UNITS  per-unit result valid.
- o_ready  out  N_UNITS  per-unit grant, one-hot or zero.
- o_cdb  out  CDB_W  broadcast word; 0 when not valid.
- o_cdb_valid  out  1  broadcast valid.
- o_grant_id  out  $clog2(N_UNITS)  index of the unit that produced o_cdb.

## Operation
- **Transfer rule.** A unit's word transfers when i_valid[k] & o_ready[k]. The unit holds i_cdb[k] and i_valid[k] stable until that transfer.
- **Combinational grant.** o_ready is combinational from i_valid, the wait counters, the RR pointer and flush.
  - At most one bit is set.
  - o_ready is never set for a unit whose i_valid is low.
  - The CDB has no backpressure: whenever any i_valid is high and flush is low, exactly one grant is issued.
- **flush = 1.**
  - o_ready = 0.
  - With OUT_REG=1, the output register loads valid = 0 at the next edge, killing any in-flight broadcast.
  - With OUT_REG=0, o_cdb_valid = 0 in the same cycle.
  - The RR pointer and the wait counters hold their values.
- **Fixed-priority mode (RR=0).**
  - Candidates are units with i_valid[k] and wait[k] == MAX_WAIT (MAX_WAIT>0). If any exist, the lowest-index candidate wins.
  - Otherwise the lowest index with i_valid set wins.
  - Wait counter per unit, width $clog2(MAX_WAIT+1):
    - increments when i_valid[k] & ~o_ready[k] & ~flush;
    - saturates at MAX_WAIT;
    - clears on grant or when i_valid[k] = 0;
    - holds during flush.
- **Round-robin mode (RR=1).**
  - Pointer p has width $clog2(N_UNITS).
  - Search order is p, p+1, … mod N_UNITS; the first valid unit wins.
  - After granting unit g, p ← (g+1) mod N_UNITS, wrapping from N_UNITS-1 to 0.
  - p does not change in cycles without a grant.
  - Wait counters are not used.
- **OUT_REG=0.**
  - o_cdb = i_cdb[g], o_cdb_valid = 1 and o_grant_id = g, all in the cycle of the grant.
  - Otherwise o_cdb = 0, o_cdb_valid = 0 and o_grant_id = 0.
- **OUT_REG=1.** The same values are registered at the edge that ends the grant cycle.

## Timing
- Latency from transfer to broadcast: 0 cycles (OUT_REG=0) or 1 cycle (OUT_REG=1).
- Throughput: one result per cycle, sustained.
- Reset (nrst low, asynchronous):
  - o_cdb = 0, o_cdb_valid = 0, o_grant_id = 0;
  - RR pointer = 0 and all wait counters = 0;
  - o_ready = 0 while nrst is low.
- Reset deasserted mid-stream: the first grant is evaluated in the first cycle with nrst high. Words that were pending before reset are not broadcast unless the unit re-presents them.
- Flush and a grant candidate in the same cycle: flush wins and no transfer occurs.
- Flush one cycle after a grant (OUT_REG=1): the registered word is already broadcast in that cycle and is not retracted. Flush affects only the next edge.
- Aging candidate and higher-priority plain request in the same cycle: the aging candidate wins.
- N_UNITS not a power of two: the RR pointer wraps at N_UNITS-1, never to an unused index.

## Test plan
- **Reset:** N_UNITS=3, OUT_REG=1. Assert nrst low mid-cycle with i_valid=3'b111 -> o_cdb_valid and o_ready drop immediately, o_cdb=0, o_grant_id=0; the first grant after release goes to unit 0.
- **Fixed priority:** RR=0, MAX_WAIT=0. i_valid=3'b110 held -> unit 1 is granted every cycle and unit 2 is never granted. With OUT_REG=1, o_cdb equals unit 1's word one cycle after each grant.
- **Aging:** RR=0, MAX_WAIT=3. Unit 0 valid continuously, unit 2 valid from cycle 0 -> unit 0 is granted in cycles 0–2; unit 2 is granted in cycle 3 with o_grant_id=2 at cycle 4; its counter is 0 in cycle 4 and unit 0 resumes.
- **Round-robin wrap:** RR=1, N_UNITS=3. All valid for 6 cycles -> grants 0,1,2,0,1,2. Then only unit 0 valid with p=1 -> unit 0 is granted and p becomes 1.
- **Flush:** OUT_REG=1. Grant unit 1 in cycle 5 with flush=1 in cycle 5 -> o_ready=0, o_cdb_valid=0 in cycle 6, and unit 1 is granted in cycle 6 if still valid. Flush in cycle 7 after a cycle-6 grant -> the cycle-7 broadcast is valid and the cycle-8 broadcast is invalid.
- **Combinational mode:** OUT_REG=0, RR=0, N_UNITS=5. Unit 4 presents word 0x5A_00000007 alone -> o_cdb=0x5A_00000007, o_cdb_valid=1 and o_grant_id=4 in the same cycle.
